// File: rtl/ej9_sweep_pkg.sv
// Shared types and constants for the function-unit sweep controller.
package ej9_sweep_pkg;

  localparam int K_DEF      = 5;
  localparam int NOUT_DEF   = 4;
  localparam int SETTLE_DEF = 1;

  // Highest input vector for a K-input function unit.
  function automatic int last_vec_of(input int k);
    return (1 << k) - 1;
  endfunction

  localparam int LAST_VEC = last_vec_of(K_DEF);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/ej9_sweep_ctrl_if.sv
// Bus between the sweep controller and its environment (function unit + host).
//
// Handshake: start is a request that the controller accepts only when it is
// not busy (IDLE or DONE); busy acts as the inverted ready. A request seen
// while busy is dropped, not queued. done/pass/err_count/fail_* are results
// that stay valid while done=1 and until the next accepted start.
interface ej9_sweep_ctrl_if #(
  parameter int K    = 5,
  parameter int NOUT = 4
);
  import ej9_sweep_pkg::*;

  logic            start;
  logic [K-1:0]    vec;
  logic [NOUT-1:0] out_full;
  logic [NOUT-1:0] out_red;
  logic            busy;
  logic            done;
  logic            pass;
  logic [K:0]      err_count;
  logic            fail_valid;
  logic [K-1:0]    fail_vec;
  logic [NOUT-1:0] fail_mask;
  state_t          dbg_state;

  modport master (
    output start, out_full, out_red,
    input  vec, busy, done, pass, err_count, fail_valid, fail_vec, fail_mask,
           dbg_state
  );

  modport slave (
    input  start, out_full, out_red,
    output vec, busy, done, pass, err_count, fail_valid, fail_vec, fail_mask,
           dbg_state
  );

endinterface

// File: rtl/ej9_sweep_cmp.sv
// Compares canonical and reduced function-unit outputs bit by bit.
module ej9_sweep_cmp #(
  parameter int NOUT = 4
) (
  input  logic [NOUT-1:0] out_full,
  input  logic [NOUT-1:0] out_red,
  output logic [NOUT-1:0] mism,
  output logic            any_mism
);

  // Per-output disagreement and its reduction.
  always_comb begin
    mism     = out_full ^ out_red;
    any_mism = |mism;
  end

endmodule

// File: rtl/ej9_sweep_ctrl.sv
// Exhaustive sweep controller: steps vec through 0..2^K-1, holds each vector
// SETTLE cycles, then compares canonical vs reduced outputs for one cycle.
// Counts mismatching vectors and latches the first failure.
// Optional build macro SWEEP_STOP_ON_FAIL_EN: end the sweep at the first
// mismatching vector instead of running all vectors.
module ej9_sweep_ctrl
  import ej9_sweep_pkg::*;
#(
  parameter int K      = K_DEF,
  parameter int SETTLE = SETTLE_DEF,
  parameter int NOUT   = NOUT_DEF
) (
  input  logic         clk,
  input  logic         reset,
  ej9_sweep_ctrl_if.slave bus
);

  localparam logic [K-1:0] LAST      = K'(last_vec_of(K));
  localparam logic [3:0]   SETTLE_M1 = 4'(SETTLE - 1);

  state_t          state_q, state_d;
  logic [K-1:0]    vec_q, vec_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [K:0]      err_q, err_d, err_inc;
  logic            fv_q, fv_d;
  logic [K-1:0]    fvec_q, fvec_d;
  logic [NOUT-1:0] fmask_q, fmask_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            finish;

  logic [NOUT-1:0] mism;
  logic            any_mism;

  ej9_sweep_cmp #(.NOUT(NOUT)) u_cmp (
    .out_full (bus.out_full),
    .out_red  (bus.out_red),
    .mism     (mism),
    .any_mism (any_mism)
  );

  // State and all registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fvec_q  <= '0;
      fmask_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fvec_q  <= fvec_d;
      fmask_q <= fmask_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fvec_d  = fvec_q;
    fmask_d = fmask_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_inc = err_q + {{K{1'b0}}, any_mism};
    finish  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_SETTLE;
          vec_d   = '0;
          cnt_d   = SETTLE_M1;
          err_d   = '0;
          fv_d    = 1'b0;
          fvec_d  = '0;
          fmask_d = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == 4'd0) state_d = ST_CHECK;
        else               cnt_d   = cnt_q - 4'd1;
      end

      ST_CHECK: begin
        err_d = err_inc;
        if (any_mism && !fv_q) begin
          fv_d    = 1'b1;
          fvec_d  = vec_q;
          fmask_d = mism;
        end
`ifdef SWEEP_STOP_ON_FAIL_EN
        finish = any_mism || (vec_q == LAST);
`else
        finish = (vec_q == LAST);
`endif
        if (finish) begin
          // vec keeps the last checked vector.
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_inc == '0);
        end else begin
          state_d = ST_SETTLE;
          vec_d   = vec_q + 1'b1;
          cnt_d   = SETTLE_M1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.vec        = vec_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.fail_valid = fv_q;
  assign bus.fail_vec   = fvec_q;
  assign bus.fail_mask  = fmask_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_ej9_sweep_ctrl.sv
// Bench for ej9_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3) driven by a
// table-based function-unit model; results compared against a model that
// derives the expected sweep outcome directly from the injected mismatches.
module tb_ej9_sweep_ctrl;
  import ej9_sweep_pkg::*;

  localparam int K    = 5;
  localparam int NOUT = 4;
  localparam int N    = LAST_VEC + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic start;
  logic sel;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [NOUT-1:0] full_tab [N];
  logic [NOUT-1:0] flip_tab [N];

  ej9_sweep_ctrl_if #(.K(K), .NOUT(NOUT)) ifa ();
  ej9_sweep_ctrl_if #(.K(K), .NOUT(NOUT)) ifb ();

  ej9_sweep_ctrl #(.K(K), .SETTLE(1), .NOUT(NOUT)) dut_a (
    .clk (clk), .reset (reset), .bus (ifa.slave)
  );
  ej9_sweep_ctrl #(.K(K), .SETTLE(3), .NOUT(NOUT)) dut_b (
    .clk (clk), .reset (reset), .bus (ifb.slave)
  );

  // Function-unit model: canonical output from a table, reduced output
  // differs by the injected flip pattern for that vector.
  assign ifa.start    = start;
  assign ifb.start    = start;
  assign ifa.out_full = full_tab[ifa.vec];
  assign ifa.out_red  = full_tab[ifa.vec] ^ flip_tab[ifa.vec];
  assign ifb.out_full = full_tab[ifb.vec];
  assign ifb.out_red  = full_tab[ifb.vec] ^ flip_tab[ifb.vec];

  wire [K-1:0]    o_vec   = sel ? ifb.vec        : ifa.vec;
  wire            o_busy  = sel ? ifb.busy       : ifa.busy;
  wire            o_done  = sel ? ifb.done       : ifa.done;
  wire            o_pass  = sel ? ifb.pass       : ifa.pass;
  wire [K:0]      o_err   = sel ? ifb.err_count  : ifa.err_count;
  wire            o_fv    = sel ? ifb.fail_valid : ifa.fail_valid;
  wire [K-1:0]    o_fvec  = sel ? ifb.fail_vec   : ifa.fail_vec;
  wire [NOUT-1:0] o_fmask = sel ? ifb.fail_mask  : ifa.fail_mask;
  wire state_t    o_state = sel ? ifb.dbg_state  : ifa.dbg_state;

  // ---------------- driver helpers ----------------
  task automatic load_tables(input int flip_density);
    for (int v = 0; v < N; v++) begin
      full_tab[v] = NOUT'($urandom);
      flip_tab[v] = '0;
      if (flip_density > 0 && $urandom_range(99, 0) < flip_density)
        flip_tab[v] = NOUT'($urandom_range(15, 1));
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- sweep runner with reference model ----------------
  task automatic run_sweep(input string name, input int settle, input bit hold);
    int exp_err, exp_first, exp_end, exp_done_edge, e;
    logic [NOUT-1:0] exp_mask;
    logic [K-1:0] exp_v;
    bit first_set, stopped, seen_done;
    bit stop_mode;
`ifdef SWEEP_STOP_ON_FAIL_EN
    stop_mode = 1'b1;
`else
    stop_mode = 1'b0;
`endif
    exp_err = 0; exp_first = 0; exp_mask = '0; exp_end = N - 1;
    first_set = 1'b0; stopped = 1'b0;
    for (int v = 0; v < N && !stopped; v++) begin
      if (flip_tab[v] != '0) begin
        exp_err++;
        if (!first_set) begin
          first_set = 1'b1; exp_first = v; exp_mask = flip_tab[v];
        end
        if (stop_mode) begin
          stopped = 1'b1; exp_end = v;
        end
      end
    end
    exp_done_edge = (exp_end + 1) * (settle + 1);

    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    checks++;
    if (o_busy !== 1'b1 || o_done !== 1'b0 || o_vec !== '0 || o_err !== '0 ||
        o_fv !== 1'b0 || o_fvec !== '0 || o_fmask !== '0) begin
      errors++;
      $display("FAIL %s start_clear: busy=%b done=%b vec=%0d err=%0d fv=%b fvec=%0d fmask=%b, required 1 0 0 0 0 0 0000",
               name, o_busy, o_done, o_vec, o_err, o_fv, o_fvec, o_fmask);
    end

    e = 0; seen_done = 1'b0;
    while (!seen_done && e < exp_done_edge + 20) begin
      @(posedge clk); #1;
      e++;
      if (o_done) begin
        seen_done = 1'b1;
        start = 1'b0;
      end else begin
        exp_v = K'(e / (settle + 1));
        checks++;
        if (o_vec !== exp_v || o_busy !== 1'b1) begin
          errors++;
          $display("FAIL %s trace@%0d: vec=%0d busy=%b, required vec=%0d busy=1",
                   name, e, o_vec, o_busy, exp_v);
        end
      end
    end
    start = 1'b0;

    checks++;
    if (!seen_done || e != exp_done_edge) begin
      errors++;
      $display("FAIL %s done_cycle: got %0d (seen=%b), required %0d",
               name, e + 1, seen_done, exp_done_edge + 1);
    end
    checks++;
    if (o_err !== (K+1)'(exp_err) || o_pass !== (exp_err == 0) || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s result: err=%0d pass=%b busy=%b, required err=%0d pass=%b busy=0",
               name, o_err, o_pass, o_busy, exp_err, (exp_err == 0));
    end
    checks++;
    if (o_fv !== first_set || o_fvec !== K'(exp_first) || o_fmask !== exp_mask) begin
      errors++;
      $display("FAIL %s first_fail: fv=%b fvec=%0d fmask=%b, required fv=%b fvec=%0d fmask=%b",
               name, o_fv, o_fvec, o_fmask, first_set, exp_first, exp_mask);
    end
    checks++;
    if (o_vec !== K'(exp_end) || o_state !== ST_DONE) begin
      errors++;
      $display("FAIL %s final_vec: vec=%0d state=%0d, required vec=%0d state=%0d",
               name, o_vec, o_state, exp_end, ST_DONE);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    sel = 1'b0;
    #1;
    checks++;
    if ({ifa.vec, ifa.busy, ifa.done, ifa.pass, ifa.err_count, ifa.fail_valid,
         ifa.fail_vec, ifa.fail_mask} !== '0 || ifa.dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_a: outputs/state not cleared (state=%0d vec=%0d busy=%b)",
               ifa.dbg_state, ifa.vec, ifa.busy);
    end
    checks++;
    if ({ifb.vec, ifb.busy, ifb.done, ifb.err_count} !== '0 || ifb.dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_b: outputs/state not cleared (state=%0d vec=%0d)",
               ifb.dbg_state, ifb.vec);
    end
  endtask

  task automatic test_clean();
    sel = 1'b0;
    load_tables(0);
    run_sweep("clean", 1, 1'b0);
  endtask

  task automatic test_two_flips();
    sel = 1'b0;
    load_tables(0);
    flip_tab[13] = 4'b0010;
    flip_tab[22] = 4'b0010;
    run_sweep("two_flips", 1, 1'b0);
  endtask

  task automatic test_random_flips();
    sel = 1'b0;
    for (int r = 0; r < 3; r++) begin
      load_tables(15);
      if (r == 1) flip_tab[0] = NOUT'($urandom_range(15, 1));
      if (r == 2) flip_tab[N-1] = NOUT'($urandom_range(15, 1));
      run_sweep($sformatf("rand%0d", r), 1, 1'b0);
    end
  endtask

  task automatic test_start_held_and_restart();
    sel = 1'b0;
    load_tables(20);
    flip_tab[7] = 4'b1000;
    run_sweep("start_held", 1, 1'b1);
    load_tables(0);
    run_sweep("restart_in_done", 1, 1'b0);
  endtask

  task automatic test_mid_reset();
    sel = 1'b0;
    load_tables(10);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({ifa.vec, ifa.busy, ifa.done, ifa.pass, ifa.err_count, ifa.fail_valid,
         ifa.fail_vec, ifa.fail_mask} !== '0 || ifa.dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL mid_reset: state=%0d vec=%0d busy=%b err=%0d, required all zero and IDLE",
               ifa.dbg_state, ifa.vec, ifa.busy, ifa.err_count);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_sweep("after_reset", 1, 1'b0);
  endtask

  task automatic test_settle3();
    pulse_reset();
    sel = 1'b1;
    load_tables(0);
    run_sweep("settle3_clean", 3, 1'b0);
    load_tables(10);
    run_sweep("settle3_rand", 3, 1'b0);
  endtask

  task automatic test_stop_on_fail();
    pulse_reset();
    sel = 1'b0;
    load_tables(0);
    flip_tab[5] = NOUT'($urandom_range(15, 1));
    run_sweep("fail_at_5", 1, 1'b0);
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    reset = 1'b1;
    start = 1'b0;
    sel   = 1'b0;
    for (int v = 0; v < N; v++) begin
      full_tab[v] = '0;
      flip_tab[v] = '0;
    end
    repeat (3) @(posedge clk);
    test_reset();
    @(negedge clk);
    reset = 1'b0;

    test_clean();
    test_two_flips();
    test_random_flips();
    test_start_held_and_restart();
    test_mid_reset();
    test_settle3();
    test_stop_on_fail();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ej9_sweep_ctrl.md
Name: ej9_sweep_ctrl

Overview:
Sequencer that exhaustively drives the 5-input combinational function unit with all input vectors 0..2^K-1, in order.
For each vector it waits a settle interval, then compares the canonical outputs {f,g,h,i} against the Karnaugh-reduced outputs {fk,gk,hk,ik}.
It counts mismatching vectors and latches the first failure.
It is the on-chip self-check for the function unit and replaces manual bench sweeps.

Parameters:
K, 5, number of function inputs; vector width.
SETTLE, 1, cycles the vector is held before comparison; legal range 1..15.
NOUT, 4, number of compared output pairs.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
start  in  1  begin a sweep; sampled only in IDLE or DONE
vec  out  K  applied input vector; vec[K-1] drives A, vec[0] drives E
out_full  in  NOUT  {f,g,h,i} from the function unit
out_red  in  NOUT  {fk,gk,hk,ik} from the function unit
busy  out  1  high while sweeping (SETTLE or CHECK)
done  out  1  high in DONE; held until the next accepted start
pass  out  1  valid when done=1; 1 when err_count==0
err_count  out  K+1  number of mismatching vectors in the current sweep
fail_valid  out  1  a mismatch has been recorded this sweep
fail_vec  out  K  first mismatching vector
fail_mask  out  NOUT  out_full^out_red at the first mismatch

Behaviour:
- Reset (asynchronous, immediate, also mid-sweep): state=IDLE. vec, busy, done, pass, err_count, fail_valid, fail_vec and fail_mask all =0.
- States: IDLE, SETTLE, CHECK, DONE. All outputs are registered.
- IDLE/DONE with start=1 → SETTLE. On that edge: vec=0, err_count=0, fail_valid=0, fail_vec=0, fail_mask=0, done=0, pass=0, busy=1, settle counter=SETTLE-1.
- start while busy is ignored.
- SETTLE: counter decrements each cycle; when counter==0 the next state is CHECK. The vector is therefore held SETTLE cycles before sampling.
- CHECK (one cycle): mism = out_full ^ out_red, sampled this cycle.
  - If mism != 0: err_count += 1.
  - If mism != 0 and fail_valid==0: fail_vec=vec, fail_mask=mism, fail_valid=1.
  - If vec == 2^K-1: → DONE. busy=0, done=1, pass=(final err_count==0). vec holds its last value.
  - Else: vec += 1, counter=SETTLE-1, → SETTLE.
- Timing: start is sampled at edge 0. The CHECK for vector n is at cycle (n+1)(SETTLE+1). done rises at cycle 2^K·(SETTLE+1)+1; with the defaults this is cycle 65.
- err_count is K+1 bits wide and needs no saturation (maximum 2^K).
- The counter for vec does not wrap inside a sweep; termination is explicit on the last vector.
- DONE is absorbing until start=1; start in DONE restarts exactly as from IDLE.

Optional Feature:
SWEEP_STOP_ON_FAIL_EN
- Defined: the first CHECK with mism != 0 goes straight to DONE, with err_count=1, pass=0, and vec holding the failing vector.
- Undefined: the full sweep always runs, as described in Behaviour.

Decomposition:
- Package ej9_sweep_pkg holds:
  - state enum (IDLE, SETTLE, CHECK, DONE),
  - default K/NOUT/SETTLE constants,
  - localparam LAST_VEC = 2^K-1.
- Sub-module ej9_sweep_cmp: purely combinational. It produces mism[NOUT-1:0] and any_mism from out_full and out_red.
- The FSM, the counters and the first-fail latch stay in the top module.

Test Plan:
1. Defaults, out_red tied to out_full, start pulse at cycle 0 → vec steps 0..31; done=1 at cycle 65; pass=1; err_count=0; fail_valid=0.
2. Model flips bit 1 of out_red at vec 13 and vec 22 → err_count=2, fail_vec=13, fail_mask=4'b0010, pass=0.
3. start held high throughout the sweep → no restart, done still at 65. A new start pulse in DONE → counters clear, sweep repeats, done at 65 cycles later.
4. reset asserted at cycle 30, mid-sweep → outputs go to 0 immediately and state=IDLE. After release, start → full sweep with correct results.
5. SETTLE=3, clean model → each vector held 3 cycles before CHECK; done at cycle 129.
6. SWEEP_STOP_ON_FAIL_EN defined, mismatch at vec 5 only → done at cycle 13, vec=5, err_count=1, fail_vec=5, pass=0.
